// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue controller in front of the 32-bit ALU.
// Accepts one instruction, reads operands, drives the ALU, then writes back.
module alu_sequencer #(
  parameter int NREGS   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr_data,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_reg8,
  output logic [15:0] alu_value,
  output logic        alu_highlow,
  output logic        alu_f1,
  output logic        alu_f2,
  output logic [6:0]  alu_instr,
  input  logic [31:0] alu_c,
  input  logic        alu_f3,
  input  logic        alu_addrch,
  input  logic [31:0] alu_naddr,
  output logic [31:0] pc,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t          r_state;
  logic [31:0]     r_ir;
  logic [31:0]     r_regs [NREGS];
  logic [31:0]     r_pc;
  logic            r_f1;
  logic            r_f2;
  logic            r_illegal;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_c;
  logic            r_f3;
  logic            r_addrch;
  logic [31:0]     r_naddr;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [31:0]     r_alu_reg8;
  logic [15:0]     r_alu_value;
  logic            r_alu_hl;
  logic            r_alu_f1;
  logic            r_alu_f2;
  logic [6:0]      r_alu_instr;

  logic [6:0]  w_op;
  logic        w_hl;
  logic [3:0]  w_rd;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [15:0] w_imm;
  logic        w_is_alu;
  logic        w_is_cmp;
  logic        w_is_jmp;
  logic        w_is_ill;
  logic        w_accept;

  assign w_op  = r_ir[6:0];
  assign w_hl  = r_ir[7];
  assign w_rd  = r_ir[11:8];
  assign w_ra  = r_ir[15:12];
  assign w_imm = r_ir[31:16];
  assign w_rb  = w_imm[3:0];

  assign w_is_alu = (w_op < 7'd8);
  assign w_is_cmp = (w_op >= 7'd8) && (w_op < 7'd14);
  assign w_is_jmp = (w_op == 7'd14) || (w_op == 7'd15);
  assign w_is_ill = (w_op >= 7'd16);

  assign instr_ready = (r_state == S_IDLE) && !reset;
  assign w_accept    = instr_valid && instr_ready;

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_reg8    = r_alu_reg8;
  assign alu_value   = r_alu_value;
  assign alu_highlow = r_alu_hl;
  assign alu_f1      = r_alu_f1;
  assign alu_f2      = r_alu_f2;
  assign alu_instr   = r_alu_instr;
  assign pc          = r_pc;
  assign illegal     = r_illegal;
  assign dbg_data    = r_regs[dbg_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ir        <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pc        <= '0;
      r_f1        <= 1'b0;
      r_f2        <= 1'b0;
      r_illegal   <= 1'b0;
      r_cnt       <= '0;
      r_c         <= '0;
      r_f3        <= 1'b0;
      r_addrch    <= 1'b0;
      r_naddr     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_reg8  <= '0;
      r_alu_value <= '0;
      r_alu_hl    <= 1'b0;
      r_alu_f1    <= 1'b0;
      r_alu_f2    <= 1'b0;
      r_alu_instr <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ir    <= instr_data;
            r_state <= S_DECODE;
          end
        end
        // Operand capture doubles as the ALU drive registers for EXEC.
        S_DECODE: begin
          r_alu_a     <= r_regs[w_ra];
          r_alu_b     <= r_regs[w_rb];
          r_alu_reg8  <= r_regs[4'd8];
          r_alu_value <= w_imm;
          r_alu_hl    <= w_hl;
          r_alu_f1    <= r_f1;
          r_alu_f2    <= r_f2;
          r_alu_instr <= w_op;
          r_cnt       <= CW'(ALU_LAT - 1);
          r_state     <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_c         <= alu_c;
            r_f3        <= alu_f3;
            r_addrch    <= alu_addrch;
            r_naddr     <= alu_naddr;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_reg8  <= '0;
            r_alu_value <= '0;
            r_alu_hl    <= 1'b0;
            r_alu_f1    <= 1'b0;
            r_alu_f2    <= 1'b0;
            r_alu_instr <= '0;
            r_state     <= S_WB;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_pc    <= r_pc + 32'd1;
          unique case (1'b1)
            w_is_alu: r_regs[w_rd] <= r_c;
            w_is_cmp: begin
              if (w_rd[0]) r_f2 <= r_f3;
              else         r_f1 <= r_f3;
            end
            w_is_jmp: begin
              if (r_addrch) r_pc <= r_naddr;
            end
            w_is_ill: r_illegal <= 1'b1;
            default: ;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue controller that sequences the 32-bit ALU datapath.
- Accepts one instruction word at a time over a valid/ready handshake and decodes it.
- Reads operands from an internal register file, drives the ALU opcode and operand ports, and waits the ALU latency.
- Then writes back the result, the F1/F2 flags or the program counter. Sits between instruction fetch and the ALU.

Parameters:
- NREGS, 16, register file depth (index width 4; fixed at 16 in this revision).
- ALU_LAT, 1, cycles the ALU outputs need to settle after inputs are driven (>=1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  instruction word present.
- instr_data  input  32  instruction word.
- instr_ready  output  1  controller can accept an instruction.
- alu_a  output  32  ALU operand A.
- alu_b  output  32  ALU operand B.
- alu_reg8  output  32  contents of r8 (jump target).
- alu_value  output  16  immediate for load-half ops.
- alu_highlow  output  1  half select for load ops.
- alu_f1  output  1  flag F1 to ALU.
- alu_f2  output  1  flag F2 to ALU.
- alu_instr  output  7  ALU opcode.
- alu_c  input  32  ALU result.
- alu_f3  input  1  ALU flag result.
- alu_addrch  input  1  ALU says take jump.
- alu_naddr  input  32  ALU jump target.
- pc  output  32  program counter.
- illegal  output  1  sticky illegal-opcode flag.
- dbg_addr  input  4  debug register index.
- dbg_data  output  32  combinational read of reg[dbg_addr].

Behaviour:
- Instruction format:
  - [6:0] op
  - [7] hl
  - [11:8] rd
  - [15:12] ra
  - [31:16] imm16
  - rb = imm16[3:0]
- FSM states: IDLE, DECODE, EXEC, WB.
- instr_ready = (state==IDLE) && !reset. A handshake occurs when instr_valid && instr_ready; the word is latched into ir.
- IDLE -> DECODE on handshake; otherwise stay in IDLE.
- DECODE (1 cycle): register opA=reg[ra], opB=reg[rb], r8=reg[8], F1/F2 copies.
- EXEC lasts exactly ALU_LAT cycles (down-counter):
  - alu_a/b/reg8/value(imm16)/highlow(hl)/f1/f2 are held stable.
  - alu_instr = op.
  - alu_c/alu_f3/alu_addrch/alu_naddr are sampled on the last EXEC cycle.
- WB (1 cycle) applies the update, then -> IDLE.
- Accept-to-next-ready = ALU_LAT+3 cycles.
- Outside EXEC, all alu_* outputs are driven 0.
- WB actions by op:
  - 0-7: reg[rd] <= sampled alu_c; pc <= pc+1.
  - 8-13: if rd[0]==0, F1 <= alu_f3, else F2 <= alu_f3; pc <= pc+1.
  - 14-15: pc <= alu_addrch ? alu_naddr : pc+1.
  - >=16: no register/flag write; illegal <= 1; pc <= pc+1. The ALU is still driven with op, and its outputs are ignored.
- pc increments wrap modulo 2^32 (0xFFFFFFFF+1 = 0).
- rd == ra is allowed: the operand was captured in DECODE, so the write in WB uses the old value.
- dbg_data reflects register writes from the cycle after WB.
- instr_valid is ignored outside IDLE; instr_data may change freely then.
- Reset (any state, including mid-EXEC):
  - Next state is IDLE; all registers, pc, F1, F2, illegal and the EXEC counter are cleared to 0.
  - All alu_* outputs are 0 in the cycle after reset is sampled.
  - No write-back of the aborted instruction occurs.
  - instr_ready is 0 while reset is high and 1 in the first cycle after it drops.

Test Plan:
- Add: r1=5, r2=7 (preloaded via op 5/6 load sequences) -> issue op0 rd=3 ra=1 rb=2 -> reg[3]=12, pc incremented once, instr_ready returns 4 cycles after accept (ALU_LAT=1).
- Compare into F2: r1=r2=9, op8 rd=1 -> F2=1, F1 unchanged, no register changed.
- Conditional jump: r8=0x40, F1=0, issue op15 -> pc=old+1. Set F1=1 via op8, reissue op15 -> pc=0x40.
- Illegal op 0x20 -> illegal=1 and stays 1 across later legal instructions; registers unchanged; pc+1.
- Reset mid-EXEC with ALU_LAT=4: assert reset on the 2nd EXEC cycle -> next cycle state IDLE, rd unwritten (0), pc=0, alu_instr=0, instr_ready=1 after reset drops.
- Backpressure and wrap: hold instr_valid high continuously -> exactly one accept per ALU_LAT+3 cycles. Set pc to 0xFFFFFFFF via op14 (r8=0xFFFFFFFF), next op0 -> pc=0.
